// File: rtl/counter_seq_checker_pkg.sv
// Shared state encodings and default widths for the counter sequence checker.
package counter_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESET  = 2'd1,
        ST_ACQ    = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_ERR_W    = 8;
    localparam int unsigned DEF_LOCK_CNT = 2;

endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// Saturating up-counter; clr takes priority over inc, so a coincident clr reads 0.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_seq_checker.sv
// Monitors a free-running counter: predicts prev+1 each clock, flags deviations
// and keeps saturating error and locked-wrap statistics.
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned ERR_W    = DEF_ERR_W,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             dut_reset_in,
    input  logic             clr,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_bad
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       run_q, run_d;
    logic [WIDTH-1:0] last_bad_q, last_bad_d;
    logic             mismatch_q;
    logic             err, wrap;
    logic [WIDTH-1:0] prev_inc;
    logic [3:0]       run_inc;

    assign prev_inc = prev_q + WIDTH'(1);
    assign run_inc  = run_q + 4'd1;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        err     = 1'b0;
        wrap    = 1'b0;
        if (dut_reset_in) begin
            // Zero check applies on every reset sample; no step check on entry.
            state_d = ST_RESET;
            prev_d  = q_in;
            run_d   = '0;
            err     = (q_in != '0);
        end else begin
            case (state_q)
                ST_IDLE, ST_RESET: begin
                    state_d = ST_ACQ;
                    prev_d  = q_in;
                    run_d   = '0;
                end
                ST_ACQ: begin
                    prev_d = q_in;
                    if (q_in == prev_inc) begin
                        run_d = run_inc;
                        if (run_inc >= 4'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    prev_d = q_in;
                    if (q_in == prev_inc) begin
                        wrap = (prev_q == '1);
                    end else begin
                        err     = 1'b1;
                        state_d = ST_ACQ;
                        run_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        last_bad_d = clr ? '0 : (err ? q_in : last_bad_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            run_q      <= '0;
            last_bad_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            last_bad_q <= last_bad_d;
            mismatch_q <= err;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (err),
        .count (err_count)
    );

    sat_counter #(.W(ERR_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (wrap),
        .count (wrap_count)
    );

    assign locked   = (state_q == ST_LOCKED);
    assign mismatch = mismatch_q;
    assign last_bad = last_bad_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker with hand-computed expectations.
module tb_counter_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] q_in;
    logic       dut_reset_in;
    logic       clr;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [3:0] last_bad;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_seq_checker #(
        .WIDTH    (4),
        .ERR_W    (8),
        .LOCK_CNT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .q_in         (q_in),
        .dut_reset_in (dut_reset_in),
        .clr          (clr),
        .locked       (locked),
        .mismatch     (mismatch),
        .err_count    (err_count),
        .wrap_count   (wrap_count),
        .last_bad     (last_bad)
    );

    // Counter-side values change on the falling edge; outputs are read 1ns after the rising edge.
    task automatic step(input logic [3:0] q, input logic dr);
        @(negedge clk);
        q_in         = q;
        dut_reset_in = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr   = 1'b0;
        step(4'd7, 1'b0);
        step(4'd7, 1'b0);
        checks++;
        if ({locked, mismatch, err_count, wrap_count, last_bad} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {locked, mismatch, err_count, wrap_count, last_bad});
        end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        step(4'd0, 1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_acq locked=%b exp=0", locked); end
        step(4'd1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_step1 locked=%b exp=0", locked); end
        step(4'd2, 1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock_rise locked=%b exp=1", locked); end
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("FAIL lock_err err_count=%0d exp=0", err_count); end
    endtask

    task automatic test_wrap();
        for (int i = 3; i <= 15; i++) begin
            step(4'(i), 1'b0);
            checks++;
            if (mismatch !== 1'b0 || locked !== 1'b1 || wrap_count !== 8'd0) begin
                failures++;
                $display("FAIL wrap_run q=%0d mismatch=%b locked=%b wrap=%0d exp=0/1/0",
                         i, mismatch, locked, wrap_count);
            end
        end
        step(4'd0, 1'b0);
        checks++;
        if (wrap_count !== 8'd1 || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL wrap_inc wrap=%0d mismatch=%b exp=1/0", wrap_count, mismatch);
        end
        step(4'd1, 1'b0);
        checks++;
        if (wrap_count !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL wrap_after wrap=%0d locked=%b exp=1/1", wrap_count, locked);
        end
    endtask

    task automatic test_error();
        for (int i = 2; i <= 5; i++) step(4'(i), 1'b0);
        step(4'd9, 1'b0);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 8'd1 || last_bad !== 4'd9 || locked !== 1'b0) begin
            failures++;
            $display("FAIL err_inject mismatch=%b err=%0d last_bad=%0d locked=%b exp=1/1/9/0",
                     mismatch, err_count, last_bad, locked);
        end
        step(4'd10, 1'b0);
        checks++;
        if (mismatch !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse mismatch=%b locked=%b exp=0/0", mismatch, locked);
        end
        step(4'd11, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL err_relock locked=%b err=%0d exp=1/1", locked, err_count);
        end
    endtask

    task automatic test_dut_reset();
        for (int i = 0; i < 2; i++) begin
            step(4'd0, 1'b1);
            checks++;
            if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== 8'd1) begin
                failures++;
                $display("FAIL dreset_zero cyc=%0d locked=%b mismatch=%b err=%0d exp=0/0/1",
                         i, locked, mismatch, err_count);
            end
        end
        step(4'd0, 1'b0);
        step(4'd1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL dreset_early locked=%b exp=0", locked); end
        step(4'd2, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL dreset_relock locked=%b err=%0d exp=1/1", locked, err_count);
        end
        for (int i = 0; i < 2; i++) begin
            step(4'd3, 1'b1);
            checks++;
            if (mismatch !== 1'b1 || err_count !== 8'(2 + i) || last_bad !== 4'd3 || locked !== 1'b0) begin
                failures++;
                $display("FAIL dreset_nonzero cyc=%0d mismatch=%b err=%0d last_bad=%0d locked=%b exp=1/%0d/3/0",
                         i, mismatch, err_count, last_bad, locked, 2 + i);
            end
        end
        step(4'd0, 1'b0);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL dreset_relock2 locked=%b exp=1", locked); end
    endtask

    task automatic test_back_to_back();
        step(4'd2, 1'b0);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 8'd4 || last_bad !== 4'd2 || locked !== 1'b0) begin
            failures++;
            $display("FAIL hold_err mismatch=%b err=%0d last_bad=%0d locked=%b exp=1/4/2/0",
                     mismatch, err_count, last_bad, locked);
        end
        step(4'd7, 1'b0);
        checks++;
        if (mismatch !== 1'b0 || err_count !== 8'd4) begin
            failures++;
            $display("FAIL acq_nocheck mismatch=%b err=%0d exp=0/4", mismatch, err_count);
        end
        step(4'd5, 1'b1);
        step(4'd6, 1'b1);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 8'd6 || last_bad !== 4'd6) begin
            failures++;
            $display("FAIL b2b_err mismatch=%b err=%0d last_bad=%0d exp=1/6/6",
                     mismatch, err_count, last_bad);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) step(4'd5, 1'b1);
        checks++;
        if (err_count !== 8'd255 || mismatch !== 1'b1) begin
            failures++;
            $display("FAIL sat_err err=%0d mismatch=%b exp=255/1", err_count, mismatch);
        end
        clr = 1'b1;
        step(4'd5, 1'b1);
        clr = 1'b0;
        checks++;
        if (err_count !== 8'd0 || wrap_count !== 8'd0 || last_bad !== 4'd0 || mismatch !== 1'b1) begin
            failures++;
            $display("FAIL clr_win err=%0d wrap=%0d last_bad=%0d mismatch=%b exp=0/0/0/1",
                     err_count, wrap_count, last_bad, mismatch);
        end
        step(4'd4, 1'b1);
        checks++;
        if (err_count !== 8'd1 || last_bad !== 4'd4) begin
            failures++;
            $display("FAIL clr_after err=%0d last_bad=%0d exp=1/4", err_count, last_bad);
        end
    endtask

    task automatic test_midreset();
        step(4'd0, 1'b0);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL mid_prelock locked=%b exp=1", locked); end
        reset = 1'b0;
        step(4'd3, 1'b0);
        reset = 1'b1;
        checks++;
        if ({locked, mismatch, err_count, wrap_count, last_bad} !== 22'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0",
                     {locked, mismatch, err_count, wrap_count, last_bad});
        end
        step(4'd5, 1'b0);
        step(4'd6, 1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL mid_acq locked=%b exp=0", locked); end
        step(4'd7, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_relock locked=%b err=%0d exp=1/0", locked, err_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        clr          = 1'b0;
        q_in         = '0;
        dut_reset_in = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_dut_reset();
        test_back_to_back();
        test_saturate();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
